prio_code_led_decoder: RTL
==========================

Name: prio_code_led_decoder

Overview:
- Counterpart to the switch-side 8-to-3 priority encoder. It accepts a {flag, code[2:0]} word over a valid/ready handshake and decodes it back to a one-hot LED pattern.
- Each accepted word is shown for a fixed hold time, followed by a blank gap. Status fields are driven on the remaining LED bits.
- Sits between the encoder/switch logic and the board `ledr[15:0]` output.

Parameters:
- HOLD_CYCLES, 4: cycles the decoded pattern is displayed; legal range ≥1.
- GAP_CYCLES, 2: blank cycles after the hold; 0 means the GAP state is skipped.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  producer has a word.
- in_flag  in  1  encoder flag; 1 means some input bit was set.
- in_code  in  3  encoded index 0..7.
- in_ready  out  1  block can accept a word this cycle.
- ledr  out  16  [7:0] pattern, [8] busy, [11:9] latched code, [15:12] accept counter.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, timer=0, ledr=16'h0000.
  - in_ready is forced 0 while rst=0.
- in_ready = (state==IDLE) && rst. It is combinational from state only, never from in_valid.
- Accept: in_valid && in_ready at a rising edge. On that same edge:
  - Register pattern = in_flag ? (8'h01 << in_code) : 8'h00.
  - code_q = in_code. This is latched even when flag=0.
  - cnt = cnt+1 mod 16; 15 wraps to 0.
  - state=SHOW, timer=HOLD_CYCLES-1.
- Latency: the pattern is visible on ledr in the cycle after the accepting edge.
- States:
  - IDLE:
    - ledr[7:0]=0 and busy=0.
    - Waits for an accept.
  - SHOW:
    - ledr[7:0]=pattern and busy=1.
    - timer decrements each cycle.
    - When timer==0 at an edge: go to GAP (timer=GAP_CYCLES-1) if GAP_CYCLES>0, else IDLE.
    - Total SHOW duration is exactly HOLD_CYCLES cycles.
  - GAP:
    - ledr[7:0]=0 and busy=1.
    - timer decrements; at timer==0 go to IDLE.
    - Duration is exactly GAP_CYCLES cycles.
- in_valid while not IDLE is ignored and not latched. The producer must hold the word until the handshake completes.
- ledr[11:9] and ledr[15:12] hold their last values through IDLE. They are cleared only by reset.
- Reset mid-SHOW/GAP: immediate return to IDLE with all outputs 0. No partial count is retained.
- Out-of-range input is impossible: the 3-bit code always decodes to a single one-hot bit.
- Timer width is $clog2(max(HOLD_CYCLES,GAP_CYCLES)+1).

Optional Feature:
- Macro: LED_THERMO_EN.
- Defined: pattern is thermometer-coded, i.e. bits [in_code:0] set when flag=1 (code 5 gives 8'h3F; flag=0 gives 8'h00).
- Undefined: one-hot as above.
- All other fields and timing are identical in both builds.

Decomposition:
- Shared package prio_led_pkg holds:
  - the state enum (IDLE=2'd0, SHOW=2'd1, GAP=2'd2);
  - the LED field offsets (PAT_LSB=0, BUSY_BIT=8, CODE_LSB=9, CNT_LSB=12);
  - the code width constant CODE_W=3.
- Sub-module code_to_pattern: purely combinational, {flag, code} → 8-bit pattern. It contains the LED_THERMO_EN switch and is reusable by other display blocks.
- Top level holds the FSM, timer, counter and output registers.

Test Plan:
- Reset:
  - Stimulus: hold rst=0 for 3 cycles with in_valid=1, then release.
  - Response: ledr=16'h0000 and in_ready=0 during reset; in_ready=1 in the first cycle after release.
- Basic accept:
  - Stimulus: flag=1, code=5 accepted at edge T.
  - Response for T+1..T+4: ledr[7:0]=8'h20, ledr[8]=1, ledr[11:9]=5, ledr[15:12]=1.
  - Response for T+5..T+6: ledr[7:0]=0 with busy=1.
  - Response at T+7: in_ready=1 and busy=0.
- Stall:
  - Stimulus: code=3 presented continuously from T+1 (during SHOW).
  - Response: not accepted until the first IDLE cycle; then ledr[7:0]=8'h08 and count=2.
- Flag zero:
  - Stimulus: flag=0, code=6 accepted.
  - Response: ledr[7:0]=0 during SHOW, ledr[11:9]=6, busy=1, count increments.
- Counter wrap:
  - Stimulus: 16 back-to-back accepts.
  - Response: ledr[15:12] reads 15 after the 15th accept and 0 after the 16th.
- Reset mid-operation and thermometer build:
  - Stimulus: assert rst during SHOW.
  - Response: ledr=0 asynchronously, before the next clock edge.
  - Stimulus: with LED_THERMO_EN defined, accept code=5.
  - Response: ledr[7:0]=8'h3F.

Source files
------------

// File: rtl/prio_led_pkg.sv
// prio_led_pkg
// Shared definitions for the priority-code LED display path.
//   - state_t   : display FSM states (IDLE, SHOW, GAP)
//   - PAT_LSB   : bit offset of the 8-bit decoded pattern on ledr
//   - BUSY_BIT  : ledr bit that is high whenever a word is being shown or gapped
//   - CODE_LSB  : bit offset of the latched 3-bit code on ledr
//   - CNT_LSB   : bit offset of the 4-bit accept counter on ledr
//   - CODE_W    : width of the encoded index coming from the priority encoder
//   - PAT_W     : width of the decoded LED pattern
//   - CNT_W     : width of the accept counter
package prio_led_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int PAT_LSB  = 0;
    localparam int BUSY_BIT = 8;
    localparam int CODE_LSB = 9;
    localparam int CNT_LSB  = 12;

    localparam int CODE_W = 3;
    localparam int PAT_W  = 8;
    localparam int CNT_W  = 4;

endpackage : prio_led_pkg

// File: rtl/prio_code_led_decoder_code_to_pattern.sv
// code_to_pattern
// Purely combinational decode of an encoder word {flag, code} into an
// 8-bit LED pattern. Reusable by any block that displays encoder output.
//
// Build option (macro LED_THERMO_EN):
//   defined   : thermometer pattern, bits [code:0] set when flag=1
//   undefined : one-hot pattern, bit [code] set when flag=1
// A clear flag always yields an all-zero pattern.
//
// Ports:
//   flag    in   1       encoder flag, 1 when some switch was set
//   code    in   CODE_W  encoded index 0..7
//   pattern out  PAT_W   decoded LED pattern
module code_to_pattern
    import prio_led_pkg::*;
(
    input  logic              flag,
    input  logic [CODE_W-1:0] code,
    output logic [PAT_W-1:0]  pattern
);

    always_comb begin
        pattern = '0;
        if (flag) begin
`ifdef LED_THERMO_EN
            // Every bit at or below the encoded index lights up.
            for (int i = 0; i < PAT_W; i++) begin
                pattern[i] = (CODE_W'(i) <= code);
            end
`else
            pattern = PAT_W'(1) << code;
`endif
        end
    end

endmodule : code_to_pattern

// File: rtl/prio_code_led_decoder.sv
// prio_code_led_decoder
// Accepts {flag, code} words from the switch-side priority encoder over a
// valid/ready handshake, shows the decoded pattern for HOLD_CYCLES cycles,
// then blanks it for GAP_CYCLES cycles before accepting the next word.
//
// Build option: LED_THERMO_EN selects a thermometer pattern instead of
// one-hot (handled inside code_to_pattern).
//
// Parameters:
//   HOLD_CYCLES  cycles the decoded pattern is displayed (>= 1)
//   GAP_CYCLES   blank cycles after the hold (0 skips the GAP state)
//
// Ports:
//   clk       in   1   system clock, rising edge
//   rst       in   1   asynchronous reset, active low
//   in_valid  in   1   producer has a word
//   in_flag   in   1   encoder flag
//   in_code   in   3   encoded index
//   in_ready  out  1   block can accept a word this cycle
//   ledr      out  16  [7:0] pattern, [8] busy, [11:9] code, [15:12] count
module prio_code_led_decoder
    import prio_led_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_flag,
    input  logic [CODE_W-1:0] in_code,
    output logic              in_ready,
    output logic [15:0]       ledr
);

    localparam int TMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    // Reload values are computed as ints first so GAP_CYCLES=0 never
    // produces a negative load.
    localparam int HOLD_LOAD_I = HOLD_CYCLES - 1;
    localparam int GAP_LOAD_I  = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_LOAD_I);
    localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_LOAD_I);

    state_t              state_q, state_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [PAT_W-1:0]    pattern_q, pattern_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PAT_W-1:0]    new_pattern;
    logic                accept;

    code_to_pattern u_code_to_pattern (
        .flag    (in_flag),
        .code    (in_code),
        .pattern (new_pattern)
    );

    // Ready depends only on state and reset, so the producer can never
    // create a combinational loop through in_valid.
    assign in_ready = (state_q == IDLE) && rst;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            pattern_q <= '0;
            code_q    <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            pattern_q <= pattern_d;
            code_q    <= code_d;
            cnt_q     <= cnt_d;
        end
    end

    // Timer counts down to zero in SHOW and GAP; a state lasts exactly
    // load+1 cycles. The code is latched even for a flag-zero word so the
    // display still reports what the encoder produced.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        pattern_d = pattern_q;
        code_d    = code_q;
        cnt_d     = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = SHOW;
                    timer_d   = HOLD_LOAD;
                    pattern_d = new_pattern;
                    code_d    = in_code;
                    cnt_d     = cnt_q + CNT_W'(1);
                end
            end
            SHOW: begin
                if (timer_q == '0) begin
                    if (GAP_CYCLES > 0) begin
                        state_d = GAP;
                        timer_d = GAP_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            GAP: begin
                if (timer_q == '0) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    // Output fields are decoded from registers only, so an asynchronous
    // reset clears the whole LED bank without waiting for a clock edge.
    always_comb begin
        ledr                        = '0;
        ledr[PAT_LSB +: PAT_W]      = (state_q == SHOW) ? pattern_q : '0;
        ledr[BUSY_BIT]              = (state_q != IDLE);
        ledr[CODE_LSB +: CODE_W]    = code_q;
        ledr[CNT_LSB +: CNT_W]      = cnt_q;
    end

endmodule : prio_code_led_decoder
